// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store initiator with alignment check, lane steering and load extension
module mem_lsu #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dp_address,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        read_dp,
  output logic        write_dp,
  input  logic [31:0] dp_readdata,
  input  logic        stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q, signed_q;
  logic [1:0]  size_q, lane_q;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        ready_nxt, valid_nxt, err_nxt, read_nxt, write_nxt;
  logic [31:0] rdata_nxt, addr_nxt, wdata_nxt;
  logic [3:0]  be_nxt;
  logic        bad_req;
  logic [31:0] shifted, ext_data;

  // Misaligned halves/words and the reserved size code never reach the memory
  assign bad_req = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Move the addressed lane down to bit 0, then sign/zero-extend by size
  always_comb begin
    shifted  = dp_readdata >> {lane_q, 3'b000};
    ext_data = dp_readdata;
    case (size_q)
      2'b00:   ext_data = signed_q ? {{24{shifted[7]}}, shifted[7:0]}  : {24'h0, shifted[7:0]};
      2'b01:   ext_data = signed_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      default: ext_data = dp_readdata;
    endcase
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    rdata_nxt = 32'h0;
    read_nxt  = 1'b0;
    write_nxt = 1'b0;
    addr_nxt  = 32'h0;
    wdata_nxt = 32'h0;
    be_nxt    = 4'h0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad_req) begin
            state_nxt = RESP;
            valid_nxt = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ACCESS;
            cnt_nxt   = '0;
            read_nxt  = ~req_we;
            write_nxt = req_we;
            addr_nxt  = {req_addr[31:2], 2'b00};
            case (req_size)
              2'b00: begin
                be_nxt    = 4'b0001 << req_addr[1:0];
                wdata_nxt = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                be_nxt    = 4'b0011 << req_addr[1:0];
                wdata_nxt = {2{req_wdata[15:0]}};
              end
              default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = req_wdata;
              end
            endcase
          end
        end
      end
      ACCESS: begin
        if (!stall) begin
          state_nxt = RESP;
          valid_nxt = 1'b1;
          rdata_nxt = we_q ? 32'h0 : ext_data;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (TIMEOUT_CYCLES != 0 && cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
            state_nxt = RESP;
            valid_nxt = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            read_nxt  = read_dp;
            write_nxt = write_dp;
            addr_nxt  = dp_address;
            wdata_nxt = writedata;
            be_nxt    = byteenable;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      dp_address <= 32'h0;
      writedata  <= 32'h0;
      byteenable <= 4'h0;
      read_dp    <= 1'b0;
      write_dp   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      req_ready  <= ready_nxt;
      resp_valid <= valid_nxt;
      resp_rdata <= rdata_nxt;
      resp_err   <= err_nxt;
      dp_address <= addr_nxt;
      writedata  <= wdata_nxt;
      byteenable <= be_nxt;
      read_dp    <= read_nxt;
      write_dp   <= write_nxt;
    end
  end

  // Request fields needed after acceptance (load extension and lane select)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
    end else if (state == IDLE && req) begin
      we_q     <= req_we;
      signed_q <= req_signed;
      size_q   <= req_size;
      lane_q   <= req_addr[1:0];
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err, read_dp, write_dp;
  logic [31:0] resp_rdata, dp_address, writedata, dp_readdata;
  logic [3:0]  byteenable;
  logic        stall = 1'b0;

  mem_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dp_address(dp_address), .writedata(writedata),
    .byteenable(byteenable), .read_dp(read_dp), .write_dp(write_dp),
    .dp_readdata(dp_readdata), .stall(stall)
  );

  always #5 clk = ~clk;

  // Memory model: 16 words, combinational read, byte-enabled write on completion
  logic [31:0] mem [16];
  assign dp_readdata = mem[dp_address[5:2]];
  always @(posedge clk) begin
    if (write_dp && !stall) begin
      for (int k = 0; k < 4; k++)
        if (byteenable[k]) mem[dp_address[5:2]][8*k +: 8] <= writedata[8*k +: 8];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Results of the last transaction
  int          lat, nstrobe;
  logic        stable, s_rd, s_wr, r_err;
  logic [31:0] s_addr, s_wd, r_rdata;
  logic [3:0]  s_be;

  task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata, input int nstall);
    int  nst;
    bit  got;
    @(negedge clk);
    req = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; nstrobe = 0; stable = 1'b1; nst = 0; got = 1'b0;
    s_rd = 0; s_wr = 0; s_addr = 0; s_wd = 0; s_be = 0; r_err = 0; r_rdata = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (read_dp || write_dp) begin
        if (nstrobe == 0) begin
          s_rd = read_dp; s_wr = write_dp; s_addr = dp_address; s_wd = writedata; s_be = byteenable;
        end else if (dp_address !== s_addr || byteenable !== s_be || writedata !== s_wd ||
                     read_dp !== s_rd || write_dp !== s_wr) begin
          stable = 1'b0;
        end
        nstrobe++;
      end
      if (resp_valid) begin
        got = 1'b1; lat = k; r_rdata = resp_rdata; r_err = resp_err;
        check("strobes_off_at_resp", {30'h0, read_dp, write_dp}, 32'h0);
      end
      stall = (read_dp || write_dp) && nst < nstall;
      if (stall) nst++;
    end
    stall = 1'b0;
    @(negedge clk);
    check("idle_after_resp", {28'h0, req_ready, resp_valid, resp_err, |resp_rdata}, 32'h8);
  endtask

  int pulses;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #12;
    check("reset_ready", {31'h0, req_ready}, 32'h1);
    check("reset_outs", {26'h0, resp_valid, resp_err, read_dp, write_dp, |byteenable, |dp_address}, 32'h0);
    @(negedge clk); rst = 1'b1;

    // SW 0x11223344 @0x10
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 0);
    check("sw_be", {28'h0, s_be}, 32'hF);
    check("sw_wd", s_wd, 32'h11223344);
    check("sw_addr", s_addr, 32'h10);
    check("sw_strobe", {30'h0, s_rd, s_wr}, 32'h1);
    check("sw_lat", lat, 2);
    check("sw_resp", {r_err, r_rdata[30:0]}, 32'h0);
    // LW @0x10
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check("lw_rdata", r_rdata, 32'h11223344);
    check("lw_lat", lat, 2);
    check("lw_strobe", {30'h0, s_rd, s_wr}, 32'h2);
    // SB 0x80 @0x13
    xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 0);
    check("sb_be", {28'h0, s_be}, 32'h8);
    check("sb_wd", s_wd, 32'h80808080);
    check("sb_addr", s_addr, 32'h10);
    xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    check("lb_rdata", r_rdata, 32'hFFFFFF80);
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    check("lbu_rdata", r_rdata, 32'h00000080);
    xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
    check("lb1_rdata", r_rdata, 32'h00000033);
    // SH 0xBEEF @0x12 -> word 0xBEEF3344
    xact(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 0);
    check("sh_be", {28'h0, s_be}, 32'hC);
    check("sh_wd", s_wd, 32'hBEEFBEEF);
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
    check("lh_rdata", r_rdata, 32'hFFFFBEEF);
    xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0);
    check("lhu_rdata", r_rdata, 32'h00003344);
    // Errors: misaligned half, misaligned word, illegal size
    xact(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0);
    check("lh_mis_err", {31'h0, r_err}, 32'h1);
    check("lh_mis_lat", lat, 1);
    check("lh_mis_nostrobe", nstrobe, 0);
    check("lh_mis_rdata", r_rdata, 32'h0);
    xact(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 0);
    check("sw_mis_err", {31'h0, r_err}, 32'h1);
    check("sw_mis_nostrobe", nstrobe, 0);
    xact(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    check("size11_err", {31'h0, r_err}, 32'h1);
    check("size11_lat", lat, 1);
    check("mem_untouched", mem[4], 32'hBEEF3344);
    // LW with 3 stall cycles
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3);
    check("stall_lat", lat, 5);
    check("stall_nstrobe", nstrobe, 4);
    check("stall_stable", {31'h0, stable}, 32'h1);
    check("stall_rdata", r_rdata, 32'hBEEF3344);
    check("stall_err", {31'h0, r_err}, 32'h0);
    // Stall stuck: timeout after 4 stalled cycles
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 100);
    check("tmo_err", {31'h0, r_err}, 32'h1);
    check("tmo_lat", lat, 5);
    check("tmo_rdata", r_rdata, 32'h0);

    // req during ACCESS is ignored: SW @0x20 stalled, second SW @0x24 pulsed mid-access
    @(negedge clk);
    req = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1 req_addr = 32'h24; req_wdata = 32'h0000DEAD;
    stall = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) begin req = 1'b0; stall = 1'b0; end
      if (resp_valid) pulses++;
    end
    check("ignore_pulses", pulses, 1);
    check("ignore_mem20", mem[8], 32'hCAFEBABE);
    check("ignore_mem24", mem[9], 32'h0);

    // Reset mid-ACCESS
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk);
    #1 req = 1'b0; stall = 1'b1;
    @(negedge clk);
    check("rst_pre_strobe", {31'h0, read_dp}, 32'h1);
    #2 rst = 1'b0;
    #1 check("rst_async_strobe", {30'h0, read_dp, write_dp}, 32'h0);
    check("rst_async_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b1; stall = 1'b0;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("rst_no_resp", pulses, 0);
    check("rst_ready_after", {31'h0, req_ready}, 32'h1);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
    check("post_rst_lw", r_rdata, 32'hCAFEBABE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
